// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and loads the IF/ID register (Curr_Pc, Curr_Instr, valid). Handles load-use
// stall, EX redirect flush and a sticky halt.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage #(
    parameter int unsigned     PC_W     = 9,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_pc,
    input  logic               halt,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [PC_W-1:0]    ifid_curr_pc,
    output logic [INSTR_W-1:0] ifid_curr_instr,
    output logic               ifid_valid,
    output logic               halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MK = ~PC_W'(3);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_d;
    logic               ifid_valid_d;

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= RUN;
            pc_q            <= RESET_PC;
            ifid_curr_pc    <= '0;
            ifid_curr_instr <= '0;
            ifid_valid      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_curr_pc    <= ifid_pc_d;
            ifid_curr_instr <= ifid_instr_d;
            ifid_valid      <= ifid_valid_d;
        end
    end

    // Next-state logic; priority in RUN is halt > flush > stall > normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_curr_pc;
        ifid_instr_d = ifid_curr_instr;
        ifid_valid_d = ifid_valid;
        if (state_q == RUN) begin
            if (halt) begin
                state_d      = HALTED;
                ifid_pc_d    = '0;
                ifid_instr_d = '0;
                ifid_valid_d = 1'b0;
            end else if (flush) begin
                pc_d         = branch_pc & ALIGN_MK;
                ifid_pc_d    = '0;
                ifid_instr_d = '0;
                ifid_valid_d = 1'b0;
            end else if (!stall) begin
                pc_d         = pc_q + PC_STEP;
                ifid_pc_d    = pc_q;
                ifid_instr_d = imem_instr;
                ifid_valid_d = 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_win, stall_win;

    assign fetch_win = (state_q == RUN) && !halt && !flush && !stall;
    assign stall_win = (state_q == RUN) && !halt && !flush && stall;

    // Saturating counters; only count in RUN, so they freeze once halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_win && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_win && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes the hand-computed expected
// state after each step; a negedge monitor pops and compares.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, halt;
    logic [8:0]  branch_pc;
    logic [8:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [8:0]  ifid_curr_pc;
    logic [31:0] ifid_curr_instr;
    logic        ifid_valid, halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [8:0] addr;
        logic [8:0] pc;
        logic       valid;
        logic       hlt;
        logic       pchk;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .branch_pc       (branch_pc),
        .halt            (halt),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .ifid_curr_pc    (ifid_curr_pc),
        .ifid_curr_instr (ifid_curr_instr),
        .ifid_valid      (ifid_valid),
        .halted          (halted)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Address-tagged instruction memory so each fetched word is distinguishable.
    assign imem_instr = {imem_addr, 23'h13};

    task automatic chk(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, field, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new IF/ID state every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "imem_addr", 32'(imem_addr), 32'(e.addr));
            chk(e.nm, "ifid_pc", 32'(ifid_curr_pc), 32'(e.pc));
            chk(e.nm, "ifid_instr", ifid_curr_instr, e.valid ? {e.pc, 23'h13} : 32'h0);
            chk(e.nm, "ifid_valid", 32'(ifid_valid), 32'(e.valid));
            chk(e.nm, "halted", 32'(halted), 32'(e.hlt));
`ifdef IF_PERF_CNT_EN
            if (e.pchk) begin
                chk(e.nm, "perf_fetch", perf_fetch_cnt, e.fcnt);
                chk(e.nm, "perf_stall", perf_stall_cnt, e.scnt);
            end
`endif
        end
    end

    task automatic push(input string nm, input logic [8:0] ea, input logic [8:0] ep,
                        input logic ev, input logic eh, input logic pc_chk,
                        input logic [31:0] fc, input logic [31:0] sc);
        exp_t e;
        e.nm = nm; e.addr = ea; e.pc = ep; e.valid = ev; e.hlt = eh;
        e.pchk = pc_chk; e.fcnt = fc; e.scnt = sc;
        exp_q.push_back(e);
    endtask

    // Drive inputs for one rising edge and record the state expected after it.
    task automatic step(input logic r, input logic s, input logic f, input logic h,
                        input logic [8:0] bpc, input string nm,
                        input logic [8:0] ea, input logic [8:0] ep,
                        input logic ev, input logic eh);
        reset = r; stall = s; flush = f; halt = h; branch_pc = bpc;
        push(nm, ea, ep, ev, eh, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic pstep(input logic r, input logic s, input logic h, input string nm,
                         input logic [8:0] ea, input logic [8:0] ep,
                         input logic ev, input logic eh,
                         input logic [31:0] fc, input logic [31:0] sc);
        reset = r; stall = s; flush = 1'b0; halt = h; branch_pc = '0;
        push(nm, ea, ep, ev, eh, 1'b1, fc, sc);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and straight-line fetch with a 2-cycle stall at PC=8.
        step(1, 0, 0, 0, 9'h000, "reset",   9'd0,  9'd0,  0, 0);
        step(0, 0, 0, 0, 9'h000, "fetch0",  9'd4,  9'd0,  1, 0);
        step(0, 0, 0, 0, 9'h000, "fetch4",  9'd8,  9'd4,  1, 0);
        step(0, 1, 0, 0, 9'h000, "stall1",  9'd8,  9'd4,  1, 0);
        step(0, 1, 0, 0, 9'h000, "stall2",  9'd8,  9'd4,  1, 0);
        step(0, 0, 0, 0, 9'h000, "unstall", 9'd12, 9'd8,  1, 0);
        step(0, 0, 0, 0, 9'h000, "fetch12", 9'd16, 9'd12, 1, 0);
        step(0, 0, 0, 0, 9'h000, "fetch16", 9'd20, 9'd16, 1, 0);
        // Flush wins over stall; low target bits are cleared.
        step(0, 1, 1, 0, 9'h0A3, "flushst", 9'h0A0, 9'd0,   0, 0);
        step(0, 0, 0, 0, 9'h000, "redir",   9'h0A4, 9'h0A0, 1, 0);
        // Get to PC=40 with a valid IF/ID, then halt alongside a flush.
        step(0, 0, 1, 0, 9'h027, "flush36", 9'd36, 9'd0,  0, 0);
        step(0, 0, 0, 0, 9'h000, "fetch36", 9'd40, 9'd36, 1, 0);
        step(0, 0, 1, 1, 9'h100, "halt",    9'd40, 9'd0,  0, 1);
        step(0, 1, 1, 0, 9'h080, "hold1",   9'd40, 9'd0,  0, 1);
        step(0, 0, 1, 0, 9'h044, "hold2",   9'd40, 9'd0,  0, 1);
        step(0, 1, 0, 0, 9'h000, "hold3",   9'd40, 9'd0,  0, 1);
        step(0, 0, 0, 1, 9'h000, "hold4",   9'd40, 9'd0,  0, 1);
        step(0, 0, 0, 0, 9'h000, "hold5",   9'd40, 9'd0,  0, 1);
        step(1, 0, 0, 0, 9'h000, "unhalt",  9'd0,  9'd0,  0, 0);
        // PC wrap-around at the top of the 9-bit space.
        step(0, 0, 1, 0, 9'h1F8, "to504",   9'd504, 9'd0,   0, 0);
        step(0, 0, 0, 0, 9'h000, "f504",    9'd508, 9'd504, 1, 0);
        step(0, 0, 0, 0, 9'h000, "f508",    9'd0,   9'd508, 1, 0);
        step(0, 0, 0, 0, 9'h000, "fwrap0",  9'd4,   9'd0,   1, 0);
        // Asynchronous reset asserted between edges, checked before the next posedge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        push("areset", 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        step(0, 0, 0, 0, 9'h000, "arel",    9'd4,  9'd0,  1, 0);
        // 6 fetches, 3 stalls, then halt; counters (when present) freeze.
        pstep(1, 0, 0, "p_rst",  9'd0,  9'd0,  0, 0, 32'd0, 32'd0);
        pstep(0, 0, 0, "p_f1",   9'd4,  9'd0,  1, 0, 32'd1, 32'd0);
        pstep(0, 0, 0, "p_f2",   9'd8,  9'd4,  1, 0, 32'd2, 32'd0);
        pstep(0, 0, 0, "p_f3",   9'd12, 9'd8,  1, 0, 32'd3, 32'd0);
        pstep(0, 0, 0, "p_f4",   9'd16, 9'd12, 1, 0, 32'd4, 32'd0);
        pstep(0, 0, 0, "p_f5",   9'd20, 9'd16, 1, 0, 32'd5, 32'd0);
        pstep(0, 0, 0, "p_f6",   9'd24, 9'd20, 1, 0, 32'd6, 32'd0);
        pstep(0, 1, 0, "p_s1",   9'd24, 9'd20, 1, 0, 32'd6, 32'd1);
        pstep(0, 1, 0, "p_s2",   9'd24, 9'd20, 1, 0, 32'd6, 32'd2);
        pstep(0, 1, 0, "p_s3",   9'd24, 9'd20, 1, 0, 32'd6, 32'd3);
        pstep(0, 0, 1, "p_halt", 9'd24, 9'd0,  0, 1, 32'd6, 32'd3);
        pstep(0, 1, 0, "p_frz1", 9'd24, 9'd0,  0, 1, 32'd6, 32'd3);
        pstep(0, 0, 0, "p_frz2", 9'd24, 9'd0,  0, 1, 32'd6, 32'd3);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the IF/ID pipeline register consumer (decode).
- Owns the PC register, drives the instruction-memory address, and produces the IF/ID payload: Curr_Pc (9-bit) and Curr_Instr (32-bit), plus a valid bit.
- Handles load-use stall, branch/jump redirect flush from EX, and the sticky halt.

Parameters:
- PC_W, 9, PC width in bits; byte address; matches Curr_Pc in the IF/ID register.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit load-use stall; hold PC and IF/ID.
- flush  input  1  taken branch/jump resolved in EX; redirect PC and bubble IF/ID.
- branch_pc  input  PC_W  redirect target; valid when flush=1.
- halt  input  1  flag_halt of the instruction in EX.
- imem_addr  output  PC_W  instruction-memory address; equals the PC register.
- imem_instr  input  INSTR_W  combinational instruction-memory read data for imem_addr.
- ifid_curr_pc  output  PC_W  IF/ID Curr_Pc.
- ifid_curr_instr  output  INSTR_W  IF/ID Curr_Instr.
- ifid_valid  output  1  1 when the IF/ID register holds a real fetched instruction.
- halted  output  1  1 once the FSM is in HALTED.

Behaviour:
- Reset (async, any state, mid-operation included):
  - PC=RESET_PC; ifid_curr_pc=0; ifid_curr_instr=0; ifid_valid=0; halted=0; FSM=RUN.
  - Release is synchronous to the next clk edge; the first fetch is from RESET_PC.
- FSM states: RUN, HALTED.
  - RUN->HALTED on any edge with halt=1.
  - HALTED is sticky; only reset exits it.
- Per-edge priority in RUN: halt > flush > stall > normal.
  - halt: PC holds; IF/ID loads a bubble (pc=0, instr=0, valid=0); FSM->HALTED. Any concurrent flush or stall is ignored.
  - flush: PC<={branch_pc[PC_W-1:2],2'b00}; the low 2 bits are forced to 0. IF/ID loads a bubble. flush overrides stall.
  - stall: PC and all IF/ID outputs hold their values.
  - normal: IF/ID<={PC, imem_instr, valid=1}; PC<=PC+4, modulo 2^PC_W.
- HALTED: PC, IF/ID and halted hold; stall, flush and halt inputs are ignored.
- imem_addr = PC register (combinational). Fetch latency is 1 cycle from PC to IF/ID.
- PC wrap-around: with PC_W=9, PC=508 steps to 0; no error is flagged.
- A flush takes effect on the edge it is sampled, so the first redirected instruction appears in IF/ID one cycle after that edge.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32).
  - perf_fetch_cnt increments on every normal load (valid=1 written).
  - perf_stall_cnt increments on every edge where stall is the winning action.
  - Both counters saturate at 32'hFFFF_FFFF, clear on reset, and freeze in HALTED.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Straight-line fetch: release reset; imem returns 32'h0000_0013 at every address; run 4 cycles -> ifid_curr_pc sequence 0,4,8,12; ifid_valid=1 from the 1st edge; imem_addr=16.
- Stall: PC=8, stall=1 for 2 cycles -> imem_addr stays 8, IF/ID holds pc=4; on release, IF/ID gets pc=8 and PC moves to 12.
- Flush over stall: PC=20, flush=1 and stall=1, branch_pc=9'h0A3 -> PC=0xA0, ifid_valid=0, ifid_curr_instr=0; next edge IF/ID pc=0xA0, valid=1.
- Halt priority and stickiness: halt=1 with flush=1 at PC=40 -> halted=1, PC stays 40, ifid_valid=0; 5 further cycles with flush/stall toggling -> no change; reset -> PC=0, halted=0.
- Wrap and async reset: PC=504, run 2 cycles -> PC=0 after 508. Assert reset mid-cycle between edges -> all outputs reach their reset values immediately, without waiting for a clk edge.
- IF_PERF_CNT_EN: 6 normal fetches, 3 stalls, then halt -> perf_fetch_cnt=6, perf_stall_cnt=3, both frozen after halt.
